hex_display_bank: RTL

- Parametrised bank of N_DISP seven-segment display registers for DE-series boards.
- Display selection is pointer-based, with optional auto-increment.
- Each write stores either a raw segment pattern or a hex digit decoded to segments.
- Write and load requests come straight from push-buttons. They are synchronised and falling-edge detected inside the block, so one press performs exactly one operation.

---
 rtl/hex_display_bank.sv | 106 ++++++++++
 1 files changed

// File: rtl/hex_display_bank.sv
// hex_display_bank: pointer-addressed bank of N_DISP active-low seven-segment registers written from push-buttons.
// Define HEX_DISPLAY_BANK_BLINK_EN to add a per-display blink attribute.
module hex_display_bank #(
    parameter int N_DISP    = 6,
    parameter int SEL_W     = 3,
    parameter int BLINK_DIV = 25000000
) (
    input  logic                CLOCK_50,
    input  logic                RESETn,
    input  logic                ld_n,
    input  logic                wr_n,
    input  logic [SEL_W-1:0]    sel,
    input  logic [6:0]          din,
    input  logic                mode,
    input  logic                auto_inc,
    input  logic                blink,
    output logic [N_DISP*7-1:0] HEX,
    output logic [SEL_W-1:0]    ptr
);
    // {previous, sync2, sync1}; a strobe is previous high with sync2 low
    logic [2:0]       r_ld, r_wr;
    logic [6:0]       r_seg [N_DISP];
    logic [SEL_W-1:0] r_ptr;
    logic             w_ld_stb, w_wr_stb, w_ld_ok, w_last;
    logic [SEL_W-1:0] w_tgt, w_nxt;
    logic [6:0]       w_data;

    function automatic logic [6:0] hex7(input logic [3:0] d);
        case (d)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    assign w_ld_stb = r_ld[2] & ~r_ld[1];
    assign w_wr_stb = r_wr[2] & ~r_wr[1];
    assign w_ld_ok  = w_ld_stb && ({1'b0, sel} < (SEL_W+1)'(N_DISP));
    assign w_tgt    = w_ld_ok ? sel : r_ptr;
    assign w_last   = w_tgt == SEL_W'(N_DISP-1);
    assign w_nxt    = w_last ? '0 : w_tgt + 1'b1;
    assign w_data   = mode ? hex7(din[3:0]) : din;
    assign ptr      = r_ptr;

    always_ff @(posedge CLOCK_50 or negedge RESETn) begin
        if (!RESETn) begin
            r_ld  <= '1;
            r_wr  <= '1;
            r_ptr <= '0;
            for (int i = 0; i < N_DISP; i++) r_seg[i] <= 7'h7F;
        end else begin
            r_ld  <= {r_ld[1:0], ld_n};
            r_wr  <= {r_wr[1:0], wr_n};
            r_ptr <= (w_wr_stb && auto_inc) ? w_nxt : w_tgt;
            for (int i = 0; i < N_DISP; i++)
                if (w_wr_stb && w_tgt == SEL_W'(i)) r_seg[i] <= w_data;
        end
    end

`ifdef HEX_DISPLAY_BANK_BLINK_EN
    localparam int CW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
    logic [CW-1:0]     r_cnt;
    logic              r_phase;
    logic [N_DISP-1:0] r_blk;
    logic              w_wrap;

    assign w_wrap = r_cnt == CW'(BLINK_DIV-1);

    always_ff @(posedge CLOCK_50 or negedge RESETn) begin
        if (!RESETn) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
            r_blk   <= '0;
        end else begin
            r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
            if (w_wrap) r_phase <= ~r_phase;
            for (int i = 0; i < N_DISP; i++)
                if (w_wr_stb && w_tgt == SEL_W'(i)) r_blk[i] <= blink;
        end
    end

    for (genvar d = 0; d < N_DISP; d++) begin : g_out
        assign HEX[7*d +: 7] = (r_phase && r_blk[d]) ? 7'h7F : r_seg[d];
    end
`else
    logic w_unused;
    assign w_unused = &{blink, BLINK_DIV > 0};

    for (genvar d = 0; d < N_DISP; d++) begin : g_out
        assign HEX[7*d +: 7] = r_seg[d];
    end
`endif
endmodule
